// File: rtl/sha_bool_fn_pipe.sv
// sha_bool_fn_pipe: two-stage pipelined SHA Ch/Maj/Parity unit with valid/ready handshake.
// Optional macro SHA_FN_COUNT_EN adds the op_count accepted-result counter port.
module sha_bool_fn_pipe #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_mode,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_y,
   input  logic [WIDTH-1:0] in_z,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
`ifdef SHA_FN_COUNT_EN
   ,
   output logic [31:0]      op_count
`endif
);

   typedef enum logic [1:0] {
      MODE_CH  = 2'b00,
      MODE_MAJ = 2'b01,
      MODE_PAR = 2'b10,
      MODE_ILL = 2'b11
   } fn_mode_t;

   logic             s1_valid;
   fn_mode_t         s1_mode;
   logic [WIDTH-1:0] s1_x;
   logic [WIDTH-1:0] s1_y;
   logic [WIDTH-1:0] s1_z;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_can_load;
   logic             s2_load;
   logic             s1_load;
   logic [WIDTH-1:0] fn_result;
   logic             fn_err;

   // in_ready is forced low while resetn is asserted so nothing is accepted on a reset edge.
   always_comb begin
      s2_can_load = !out_valid | out_ready;
      s2_load     = s1_valid & s2_can_load;
      in_ready    = resetn & (!s1_valid | s2_can_load);
      s1_load     = in_valid & in_ready;
   end

   always_comb begin
      fn_result = '0;
      fn_err    = 1'b0;
      case (s1_mode)
         MODE_CH:  fn_result = (s1_x & s1_y) ^ (~s1_x & s1_z);
         MODE_MAJ: fn_result = (s1_x & s1_y) ^ (s1_x & s1_z) ^ (s1_y & s1_z);
         MODE_PAR: fn_result = s1_x ^ s1_y ^ s1_z;
         default: begin
            fn_result = '0;
            fn_err    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
         s1_mode  <= fn_mode_t'(in_mode);
         s1_x     <= in_x;
         s1_y     <= in_y;
         s1_z     <= in_z;
         s1_tag   <= in_tag;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Output registers only change on a load, so they hold through any stall.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
         out_err   <= 1'b0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         out_data  <= fn_result;
         out_tag   <= s1_tag;
         out_err   <= fn_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef SHA_FN_COUNT_EN
   always_ff @(posedge clk) begin
      if (!resetn) begin
         op_count <= '0;
      end else if (out_valid & out_ready) begin
         op_count <= op_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sha_bool_fn_pipe.sv
// tb_sha_bool_fn_pipe: directed, table-driven bench for sha_bool_fn_pipe (64- and 32-bit instances).
// Covers latency, all modes, illegal mode, backpressure ordering/stability, mid-stream reset and op_count.
module tb_sha_bool_fn_pipe;

   logic        clk = 1'b0;
   logic        resetn;

   logic        in_valid, in_ready, out_valid, out_ready, out_err;
   logic [1:0]  in_mode;
   logic [63:0] in_x, in_y, in_z, out_data;
   logic [3:0]  in_tag, out_tag;

   logic        in_valid32, in_ready32, out_valid32, out_err32;
   logic [1:0]  in_mode32;
   logic [31:0] in_x32, in_y32, in_z32, out_data32;
   logic [3:0]  out_tag32;
`ifdef SHA_FN_COUNT_EN
   logic [31:0] op_count, op_count32;
`endif

   int unsigned passed = 0;
   int unsigned total  = 0;

   always #5 clk = ~clk;

   sha_bool_fn_pipe #(.WIDTH(64), .TAG_W(4)) dut64 (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_err(out_err)
`ifdef SHA_FN_COUNT_EN
      , .op_count(op_count)
`endif
   );

   sha_bool_fn_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid32), .in_ready(in_ready32), .in_mode(in_mode32),
      .in_x(in_x32), .in_y(in_y32), .in_z(in_z32), .in_tag(4'h5),
      .out_valid(out_valid32), .out_ready(1'b1), .out_data(out_data32),
      .out_tag(out_tag32), .out_err(out_err32)
`ifdef SHA_FN_COUNT_EN
      , .op_count(op_count32)
`endif
   );

   typedef struct {
      logic [1:0]  mode;
      logic [63:0] x, y, z;
      logic [3:0]  tag;
      logic [63:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model written in select/majority-vote form.
   function automatic logic [63:0] model(input logic [1:0] m, input logic [63:0] x, input logic [63:0] y,
                                         input logic [63:0] z);
      case (m)
         2'b00:   return (x & y) | (~x & z);
         2'b01:   return (x & y) | (x & z) | (y & z);
         2'b10:   return x ^ y ^ z;
         default: return 64'h0;
      endcase
   endfunction

   // Issue one op into an empty pipe with out_ready=1 and check the 2-edge latency.
   task automatic send_check(input vec_t v, input string nm);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_mode   = v.mode;
      in_x      = v.x;
      in_y      = v.y;
      in_z      = v.z;
      in_tag    = v.tag;
      #1 chk({nm, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk({nm, "_valid_n1"}, out_valid, 0);
      @(posedge clk);
      #1 chk({nm, "_valid_n2"}, out_valid, 1);
      chk({nm, "_data"}, out_data, v.exp_data);
      chk({nm, "_tag"}, out_tag, v.tag);
      chk({nm, "_err"}, out_err, v.exp_err);
   endtask

   task automatic send32(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z, input logic [31:0] exp, input string nm);
      @(negedge clk);
      in_valid32 = 1'b1;
      in_mode32  = m;
      in_x32     = x;
      in_y32     = y;
      in_z32     = z;
      @(posedge clk);
      #1 in_valid32 = 1'b0;
      chk({nm, "_valid_n1"}, out_valid32, 0);
      @(posedge clk);
      #1 chk({nm, "_valid_n2"}, out_valid32, 1);
      chk({nm, "_data"}, out_data32, exp);
      chk({nm, "_err"}, out_err32, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] exp_q [$];
      logic [3:0]  tag_q [$];
      int          sent, got, cyc, inflight;
      logic        stall_prev;
      logic [63:0] prev_data;
      logic [3:0]  prev_tag;
      logic [3:0]  t;

      resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_mode = '0;
      in_x = '0; in_y = '0; in_z = '0; in_tag = '0;
      in_valid32 = 1'b0; in_mode32 = '0; in_x32 = '0; in_y32 = '0; in_z32 = '0;

      // Ch selects y where x=1 and z where x=0.
      vecs[0] = '{2'b00, 64'hF0F0F0F0F0F0F0F0, 64'hFFFFFFFF00000000, 64'h123456789ABCDEF0, 4'h1,
                  64'hF2F4F6F80A0C0E00, 1'b0};
      vecs[1] = '{2'b01, 64'h00000000FF00FF00, 64'h000000000FF00FF0, 64'h00000000AAAAAAAA, 4'h2,
                  64'h00000000AFA0AFA0, 1'b0};
      vecs[2] = '{2'b10, 64'h00000000FF00FF00, 64'h000000000FF00FF0, 64'h00000000AAAAAAAA, 4'h3,
                  64'h000000005A5A5A5A, 1'b0};
      vecs[3] = '{2'b11, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 4'h9,
                  64'h0, 1'b1};
      vecs[4] = '{2'b00, 64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 4'hA,
                  64'h0123456789ABCDEF, 1'b0};
      vecs[5] = '{2'b00, 64'h0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 4'hB,
                  64'hFEDCBA9876543210, 1'b0};
      vecs[6] = '{2'b01, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h5555555555555555, 4'hC,
                  64'h5555555555555555, 1'b0};
      vecs[7] = '{2'b10, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001, 4'hD,
                  64'h8000000000000001, 1'b0};

      repeat (2) @(posedge clk);
      #1 chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_err", out_err, 0);
      @(negedge clk) resetn = 1'b1;
      #1 chk("rel_in_ready", in_ready, 1);

      for (int unsigned i = 0; i < 8; i++) send_check(vecs[i], $sformatf("vec%0d", i));

      send32(2'b01, 32'hFF00FF00, 32'h0FF00FF0, 32'hAAAAAAAA, 32'hAFA0AFA0, "w32_maj");
      send32(2'b10, 32'hFF00FF00, 32'h0FF00FF0, 32'hAAAAAAAA, 32'h5A5A5A5A, "w32_par");

      // Backpressure stream: out_ready pattern 1,0,0 repeating.
      sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; prev_data = '0; prev_tag = '0;
      while (got < 8 && cyc < 200) begin
         @(negedge clk);
         out_ready = (cyc % 3 == 0);
         if (sent < 8) begin
            t        = 4'(sent);
            in_valid = 1'b1;
            in_mode  = 2'(sent % 3);
            in_x     = {16{t}};
            in_y     = 64'hA5A5A5A5A5A5A5A5 ^ {t, 60'h0};
            in_z     = 64'h0F0F00FF3C3CC3C3 + 64'(sent);
            in_tag   = t;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         inflight = sent - got;
         chk("bp_in_ready", in_ready, (inflight < 2) || out_ready);
         if (stall_prev) begin
            chk("bp_stall_valid", out_valid, 1);
            chk("bp_stall_data", out_data, prev_data);
            chk("bp_stall_tag", out_tag, prev_tag);
         end
         if (out_valid && out_ready) begin
            if (tag_q.size() == 0) begin
               chk("bp_unexpected_output", out_tag, 4'hF ^ out_tag);
            end else begin
               chk("bp_order_tag", out_tag, tag_q.pop_front());
               chk("bp_order_data", out_data, exp_q.pop_front());
               chk("bp_err", out_err, 0);
            end
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_mode, in_x, in_y, in_z));
            tag_q.push_back(in_tag);
            sent++;
         end
         stall_prev = out_valid && !out_ready;
         prev_data  = out_data;
         prev_tag   = out_tag;
         @(posedge clk);
         cyc++;
      end
      chk("bp_all_received", 64'(got), 8);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("bp_drained", out_valid, 0);

      // Mid-stream reset with two ops in flight.
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = vecs[4].mode; in_x = vecs[4].x; in_y = vecs[4].y;
      in_z = vecs[4].z; in_tag = vecs[4].tag;
      @(posedge clk);
      #1 in_tag = 4'h6;
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("mid_pre_valid", out_valid, 1);
      chk("mid_pre_data", out_data, vecs[4].exp_data);
      chk("mid_full_in_ready", in_ready, 0);
      @(negedge clk) resetn = 1'b0;
      @(posedge clk);
      #1 chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_tag", out_tag, 0);
      chk("mid_rst_in_ready", in_ready, 0);
`ifdef SHA_FN_COUNT_EN
      chk("mid_rst_count", op_count, 0);
`endif
      @(negedge clk) resetn = 1'b1;
      #1 chk("mid_rel_in_ready", in_ready, 1);
      chk("mid_rel_valid", out_valid, 0);
      send_check(vecs[0], "post_rst");

`ifdef SHA_FN_COUNT_EN
      @(posedge clk);
      @(negedge clk) force dut64.op_count = 32'hFFFFFFFE;
      @(negedge clk) release dut64.op_count;
      send_check(vecs[2], "cnt0");
      @(posedge clk);
      #1 chk("cnt_ffffffff", op_count, 32'hFFFFFFFF);
      send_check(vecs[3], "cnt1");
      @(posedge clk);
      #1 chk("cnt_wrap0", op_count, 32'h0);
      send_check(vecs[5], "cnt2");
      @(posedge clk);
      #1 chk("cnt_one", op_count, 32'h1);
`endif

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
